bridge_arbiter: RTL and testbench

- Shares one downstream bridge port between NUM_REQ internal requesters, e.g. a host-side bridge leaf plus a soft-CPU or DMA master.
- Runs one transaction at a time, granting requesters round-robin.
- Issues single-cycle rd/wr strobes with addr/wr_data held stable for the whole transaction, waits a fixed read latency, and returns data or a write ack to the granted requester only.
- Sits between the requesters and a leaf port of the bridge master fabric.

---
 rtl/bridge_arbiter.sv | 136 +++++++++++++
 tb/tb_bridge_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bridge_arbiter.sv
// Round-robin arbiter sharing one downstream bridge port among NUM_REQ requesters.
// One transaction in flight at a time; responses return only to the granted requester.
module bridge_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int RD_LATENCY = 3,
    parameter int WR_HOLD    = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_wr,
    input  logic [NUM_REQ*32-1:0]  req_addr,
    input  logic [NUM_REQ*32-1:0]  req_wr_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [31:0]            rsp_rd_data,
    output logic [31:0]            bridge_addr,
    output logic [31:0]            bridge_wr_data,
    output logic                   bridge_wr,
    output logic                   bridge_rd,
    input  logic [31:0]            bridge_rd_data
);

    generate
        if (NUM_REQ < 1) begin : g_bad_num_req
            $error("bridge_arbiter: NUM_REQ must be >= 1");
        end
        if (RD_LATENCY < 1) begin : g_bad_rd_latency
            $error("bridge_arbiter: RD_LATENCY must be >= 1");
        end
        if (WR_HOLD < 0) begin : g_bad_wr_hold
            $error("bridge_arbiter: WR_HOLD must be >= 0");
        end
    endgenerate

    localparam int unsigned NR   = NUM_REQ;
    localparam int          GW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int          MAXC = (RD_LATENCY > WR_HOLD) ? RD_LATENCY : WR_HOLD;
    localparam int          CW   = $clog2(MAXC + 1);
    localparam logic [GW-1:0] LAST_INIT = GW'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t          state, state_nx;
    logic [GW-1:0]   pick, grant_q, last_grant;
    logic            pick_found, accept, wr_q;
    logic [CW-1:0]   cnt;

    // Search starts just past the last winner, so a requester that was just
    // served sits behind every other pending requester.
    always_comb begin : p_pick
        int unsigned j;
        logic [GW-1:0] jj;
        pick       = '0;
        pick_found = 1'b0;
        j          = 0;
        jj         = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            j = 32'(last_grant) + 32'd1 + i;
            if (j >= NR) j = j - NR;
            jj = GW'(j);
            if (!pick_found && req_valid[jj]) begin
                pick       = jj;
                pick_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        req_ready = '0;
        rsp_valid = '0;
        bridge_rd = 1'b0;
        bridge_wr = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                // Gated by reset_n so no accept pulse leaks out while held in reset.
                if (pick_found && reset_n) begin
                    accept          = 1'b1;
                    req_ready[pick] = 1'b1;
                    state_nx        = ISSUE;
                end
            end
            ISSUE: begin
                bridge_wr = wr_q;
                bridge_rd = !wr_q;
                state_nx  = (wr_q && (WR_HOLD == 0)) ? DONE : WAIT;
            end
            WAIT: begin
                if (cnt == CW'(1)) state_nx = DONE;
            end
            DONE: begin
                rsp_valid[grant_q] = 1'b1;
                state_nx           = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_q        <= '0;
            last_grant     <= LAST_INIT;
            wr_q           <= 1'b0;
            cnt            <= '0;
            bridge_addr    <= '0;
            bridge_wr_data <= '0;
            rsp_rd_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        grant_q        <= pick;
                        wr_q           <= req_wr[pick];
                        bridge_addr    <= req_addr[32*pick +: 32];
                        bridge_wr_data <= req_wr_data[32*pick +: 32];
                    end
                end
                ISSUE: cnt <= wr_q ? CW'(WR_HOLD) : CW'(RD_LATENCY);
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (!wr_q && (cnt == CW'(1))) rsp_rd_data <= bridge_rd_data;
                end
                DONE: last_grant <= grant_q;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bridge_arbiter.sv
// Self-checking bench for bridge_arbiter (NUM_REQ=3): table-driven single transactions
// plus hand sequences, with accept/strobe/response scoreboards checked by a monitor.
module tb_bridge_arbiter;

    localparam int NR      = 3;
    localparam int RD_LAT  = 3;
    localparam int WR_HOLD = 1;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NR-1:0]     req_valid, req_wr, req_ready, rsp_valid;
    logic [NR*32-1:0]  req_addr, req_wr_data;
    logic [31:0]       rsp_rd_data, bridge_addr, bridge_wr_data, bridge_rd_data;
    logic              bridge_wr, bridge_rd;

    bridge_arbiter #(.NUM_REQ(NR), .RD_LATENCY(RD_LAT), .WR_HOLD(WR_HOLD)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wr_data(req_wr_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rd_data(rsp_rd_data),
        .bridge_addr(bridge_addr), .bridge_wr_data(bridge_wr_data),
        .bridge_wr(bridge_wr), .bridge_rd(bridge_rd), .bridge_rd_data(bridge_rd_data)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct { int unsigned cyc; int idx; } acc_t;
    typedef struct { int unsigned cyc; logic wr; logic [31:0] addr; logic [31:0] data; } stb_t;
    typedef struct { int unsigned cyc; int idx; logic wr; logic [31:0] data; } rsp_t;

    acc_t acc_q[$];
    stb_t stb_q[$];
    rsp_t rsp_q[$];
    logic [31:0] last_rd_exp = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexp(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %h, required no event (cycle %0d)", name, act, cyc);
    endtask

    function automatic logic [31:0] onehot(input int idx);
        logic [31:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return 32'hCAFE_F00D ^ a ^ 32'h0000_1000;
    endfunction

    // Downstream memory: data is valid only in the cycle RD_LAT after bridge_rd.
    int          rd_cd = 0;
    bit          rd_active = 0;
    logic [31:0] rd_addr = '0;
    always @(negedge clk) begin
        if (rd_active) rd_cd--;
        if (rd_active && rd_cd == 0) begin
            bridge_rd_data = rd_model(rd_addr);
            rd_active = 0;
        end else begin
            bridge_rd_data = 32'h5A5A_0000 ^ cyc;
        end
        if (bridge_rd) begin
            rd_active = 1;
            rd_cd     = RD_LAT;
            rd_addr   = bridge_addr;
        end
    end

    acc_t ma;
    stb_t ms;
    rsp_t mr;
    always @(negedge clk) begin
        if (req_ready != '0) begin
            if (acc_q.size() == 0) unexp("accept", 32'(req_ready));
            else begin
                ma = acc_q.pop_front();
                chk("accept_cycle", cyc, ma.cyc);
                chk("accept_onehot", 32'(req_ready), onehot(ma.idx));
            end
        end
        if (bridge_rd || bridge_wr) begin
            chk("single_strobe", 32'(bridge_rd & bridge_wr), 32'd0);
            if (stb_q.size() == 0) unexp("strobe", {bridge_wr, bridge_rd});
            else begin
                ms = stb_q.pop_front();
                chk("strobe_cycle", cyc, ms.cyc);
                chk("strobe_is_wr", 32'(bridge_wr), 32'(ms.wr));
                chk("strobe_addr", bridge_addr, ms.addr);
                if (ms.wr) chk("strobe_wdata", bridge_wr_data, ms.data);
            end
        end
        if (rsp_valid != '0) begin
            if (rsp_q.size() == 0) unexp("response", 32'(rsp_valid));
            else begin
                mr = rsp_q.pop_front();
                chk("rsp_cycle", cyc, mr.cyc);
                chk("rsp_onehot", 32'(rsp_valid), onehot(mr.idx));
                if (!mr.wr) begin
                    chk("rsp_rd_data", rsp_rd_data, mr.data);
                    last_rd_exp = mr.data;
                end else begin
                    chk("rsp_rd_data_held", rsp_rd_data, last_rd_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int unsigned c);
        while (cyc < c) tick();
    endtask

    task automatic drive(input int idx, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        req_valid[idx]            = 1'b1;
        req_wr[idx]               = wr;
        req_addr[32*idx +: 32]    = addr;
        req_wr_data[32*idx +: 32] = wdata;
    endtask

    task automatic exp_txn(input int unsigned t, input int idx, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int unsigned rcyc, input logic [31:0] rdata, input bit with_rsp);
        acc_q.push_back('{t, idx});
        stb_q.push_back('{t + 1, wr, addr, wdata});
        if (with_rsp) rsp_q.push_back('{rcyc, idx, wr, rdata});
    endtask

    typedef struct {
        int          idx;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int unsigned lat;
        logic [31:0] rdata;
    } vec_t;

    vec_t        vecs[5];
    int unsigned t, tr;

    initial begin
        vecs[0] = '{0, 1'b0, 32'h0000_1000, 32'h0,          5, 32'hCAFE_F00D};
        vecs[1] = '{2, 1'b1, 32'h0000_0040, 32'h1234_5678,  3, 32'h0};
        vecs[2] = '{1, 1'b0, 32'h0000_2000, 32'h0,          5, 32'hCAFE_C00D};
        vecs[3] = '{0, 1'b1, 32'h0000_0000, 32'hA5A5_A5A5,  3, 32'h0};
        vecs[4] = '{2, 1'b0, 32'h0000_0000, 32'h0,          5, 32'hCAFE_E00D};

        reset_n = 1'b0;
        req_valid = '0; req_wr = '0; req_addr = '0; req_wr_data = '0;
        repeat (2) tick();
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_strobes", {30'd0, bridge_wr, bridge_rd}, 32'd0);
        chk("reset_addr", bridge_addr, 32'd0);
        chk("reset_wdata", bridge_wr_data, 32'd0);
        chk("reset_rd_data", rsp_rd_data, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        for (int k = 0; k < 5; k++) begin
            t = cyc;
            drive(vecs[k].idx, vecs[k].wr, vecs[k].addr, vecs[k].wdata);
            exp_txn(t, vecs[k].idx, vecs[k].wr, vecs[k].addr, vecs[k].wdata,
                    t + vecs[k].lat, vecs[k].rdata, 1);
            tick();
            req_valid[vecs[k].idx] = 1'b0;
            wait_until(t + vecs[k].lat + 1);
        end

        // Contention between req0 and req1 (last winner was 2): 0,1,0,1.
        t = cyc;
        drive(0, 1'b0, 32'h1000, 32'h0);
        drive(1, 1'b0, 32'h2000, 32'h0);
        exp_txn(t,      0, 1'b0, 32'h1000, 32'h0, t + 5,  32'hCAFE_F00D, 1);
        exp_txn(t + 6,  1, 1'b0, 32'h2000, 32'h0, t + 11, 32'hCAFE_C00D, 1);
        exp_txn(t + 12, 0, 1'b0, 32'h1000, 32'h0, t + 17, 32'hCAFE_F00D, 1);
        exp_txn(t + 18, 1, 1'b0, 32'h2000, 32'h0, t + 23, 32'hCAFE_C00D, 1);
        wait_until(t + 19);
        req_valid = '0;
        wait_until(t + 24);

        // Fairness: req2 joins while req0/req1 saturate; order 0,1,2,0.
        t = cyc;
        drive(0, 1'b0, 32'h1000, 32'h0);
        drive(1, 1'b0, 32'h2000, 32'h0);
        exp_txn(t,      0, 1'b0, 32'h1000, 32'h0, t + 5,  32'hCAFE_F00D, 1);
        exp_txn(t + 6,  1, 1'b0, 32'h2000, 32'h0, t + 11, 32'hCAFE_C00D, 1);
        exp_txn(t + 12, 2, 1'b0, 32'h1004, 32'h0, t + 17, 32'hCAFE_F009, 1);
        exp_txn(t + 18, 0, 1'b0, 32'h1000, 32'h0, t + 23, 32'hCAFE_F00D, 1);
        wait_until(t + 2);
        drive(2, 1'b0, 32'h1004, 32'h0);
        wait_until(t + 13);
        req_valid[2] = 1'b0;
        wait_until(t + 19);
        req_valid = '0;
        wait_until(t + 24);

        // Single write from req1 with a 1-cycle req0 blip while busy.
        t = cyc;
        drive(1, 1'b1, 32'h20, 32'hDEAD_BEEF);
        exp_txn(t, 1, 1'b1, 32'h20, 32'hDEAD_BEEF, t + 2 + WR_HOLD, 32'h0, 1);
        tick();
        req_valid[1] = 1'b0;
        drive(0, 1'b0, 32'h3000, 32'h0);
        for (int d = 1; d <= 4; d++) begin
            @(negedge clk);
            chk("wr_addr_held", bridge_addr, 32'h20);
            chk("wr_data_held", bridge_wr_data, 32'hDEAD_BEEF);
            tick();
            req_valid[0] = 1'b0;
        end
        wait_until(t + 10);

        // Reset during WAIT of a read: abandoned, then req0 wins over req1.
        t = cyc;
        drive(2, 1'b0, 32'h3000, 32'h0);
        exp_txn(t, 2, 1'b0, 32'h3000, 32'h0, 0, 32'h0, 0);
        tick();
        req_valid[2] = 1'b0;
        wait_until(t + 3);
        reset_n = 1'b0;
        last_rd_exp = '0;
        drive(1, 1'b0, 32'h2000, 32'h0);
        drive(0, 1'b0, 32'h1000, 32'h0);
        @(negedge clk);
        chk("midrst_strobes", {30'd0, bridge_wr, bridge_rd}, 32'd0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        chk("midrst_addr", bridge_addr, 32'd0);
        chk("midrst_rd_data", rsp_rd_data, 32'd0);
        tick();
        @(negedge clk);
        chk("inrst_req_ready", 32'(req_ready), 32'd0);
        tick();
        reset_n = 1'b1;
        tr = cyc;
        exp_txn(tr,     0, 1'b0, 32'h1000, 32'h0, tr + 5,  32'hCAFE_F00D, 1);
        exp_txn(tr + 6, 1, 1'b0, 32'h2000, 32'h0, tr + 11, 32'hCAFE_C00D, 1);
        tick();
        req_valid[0] = 1'b0;
        wait_until(tr + 7);
        req_valid[1] = 1'b0;
        wait_until(tr + 14);

        chk("pending_accepts", acc_q.size(), 32'd0);
        chk("pending_strobes", stb_q.size(), 32'd0);
        chk("pending_responses", rsp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
